mult_8x8_quad_seq: RTL
======================

// Module: mult_8x8_quad_seq
// PURPOSE
//  Time-multiplexed 8x8 approximate multiplier controller. Accepts one A/B pair over
//  a valid/ready handshake and issues the four 4x4 quadrant products serially to ONE
//  external 4x4 multiplier. The multiplier may be any N2/R2/R1 variant, or a mux of
//  them steered by q_sel. Combines the returned partial products by exact add or by
//  OR-combine, then presents R. Area-reduced alternative to the 4-instance 8x8 variants.
// PARAMETERS
//  MUL_LAT  0  register stages inside the attached 4x4 multiplier (legal 0..3)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair A/B/mode valid
//  in_ready   out  1   controller can accept an operand pair
//  A          in   8   multiplicand
//  B          in   8   multiplier
//  mode       in   1   0 = exact add combine, 1 = OR combine
//  out_valid  out  1   R valid
//  out_ready  in   1   consumer accepts R
//  R          out  16  combined product
//  q_a        out  4   quadrant operand A nibble to the 4x4 multiplier
//  q_b        out  4   quadrant operand B nibble to the 4x4 multiplier
//  q_sel      out  2   current quadrant index 0..3 (variant steering)
//  q_valid    out  1   one-cycle issue strobe for q_a/q_b
//  q_p        in   8   4x4 product, valid MUL_LAT cycles after q_valid
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst high at an edge): state IDLE.
//   - Cleared: acc, R, out_valid, q_valid, q_a, q_b, q_sel, busy.
//   - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst falls.
//  FSM: IDLE -> Q0 -> Q1 -> Q2 -> Q3 -> DONE -> IDLE.
//  IDLE:
//   - in_ready = 1.
//   - Accept when in_valid & in_ready: latch A, B and mode; clear acc; go to Q0.
//  Qk slot (k = 0..3) lasts MUL_LAT+1 cycles.
//   - First cycle of the slot: q_valid = 1, q_sel = k, and q_a/q_b driven as:
//       k=0: A[3:0] x B[3:0], shift 0
//       k=1: A[3:0] x B[7:4], shift 4
//       k=2: A[7:4] x B[3:0], shift 4
//       k=3: A[7:4] x B[7:4], shift 8
//   - Last cycle of the slot: sample q_p. With MUL_LAT = 0 this is the issue cycle.
//       mode 0: acc <= acc + (q_p << shift), truncated to 16 bits (mod 2^16 wrap).
//       mode 1: acc <= acc | (q_p << shift).
//   - Outside issue cycles: q_valid = 0, q_a = 0, q_b = 0; q_sel holds k.
//  DONE:
//   - out_valid = 1, R = acc, held stable until out_valid & out_ready, then go to IDLE.
//   - out_valid and R are registered; R holds its last value after the handshake.
//  Latency: call the accept cycle cycle 0.
//   - q_valid pulses at cycles 1 + k*(MUL_LAT+1).
//   - out_valid first high at cycle 4*(MUL_LAT+1)+1.
//  Throughput, with out_ready tied high: one op per 4*(MUL_LAT+1)+2 cycles.
//  Boundaries:
//   - in_ready = 0 outside IDLE; in_valid there is ignored, and A/B/mode changes after
//     accept have no effect.
//   - Back-pressure: with out_ready low, DONE holds indefinitely with R stable.
//   - No accept in the DONE cycle that handshakes; the next accept is earliest in IDLE.
//   - rst mid-operation aborts immediately: next cycle is IDLE, no out_valid.
//     A q_p returning later is ignored.
//   - An approximate q_p up to 0xFF can overflow 16 bits in mode 0; wrap mod 2^16,
//     no saturation, no flag.
// TESTING (bench attaches an exact 4x4 model unless stated)
//  1. MUL_LAT=0, A=0x12, B=0x34, mode 0 -> R=0x03A8; out_valid at cycle 5;
//     q_valid at cycles 1,2,3,4.
//  2. A=0xFF, B=0xFF: mode 0 -> R=0xFE01; mode 1 -> R=0xEFF1.
//  3. Model returns 0xFF for every quadrant, mode 0 -> R=0x1FDF (wrap).
//  4. out_ready low 10 cycles in DONE -> R and out_valid stable, in_ready 0,
//     a new in_valid is not accepted.
//  5. rst pulsed at cycle 3 of an op -> next cycle IDLE, out_valid 0;
//     then A=3, B=5, mode 0 -> R=15.
//  6. MUL_LAT=2, A=0x12, B=0x34 -> q_valid at cycles 1,4,7,10;
//     out_valid at cycle 13; R=0x03A8.

Source files
------------

// File: rtl/mult_8x8_quad_seq.sv
// ---------------------------------------------------------------------------
// mult_8x8_quad_seq
// Time-multiplexed 8x8 multiplier controller. One A/B pair is accepted over a
// valid/ready handshake. Its four 4x4 quadrant products are issued one after
// another to a single external 4x4 multiplier (exact or approximate). The
// returned partial products are combined by exact add (mode 0) or by bitwise
// OR (mode 1), and the result is presented on R with a valid/ready handshake.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready operand handshake for A, B, mode
//   A, B              8-bit operands
//   mode              0 = add combine, 1 = OR combine
//   out_valid/out_ready result handshake for R
//   R                 16-bit combined product (wraps mod 2^16 in mode 0)
//   q_a, q_b          nibble operands to the external 4x4 multiplier
//   q_sel             quadrant index 0..3 (variant steering)
//   q_valid           one-cycle issue strobe for q_a/q_b
//   q_p               4x4 product, valid MUL_LAT cycles after q_valid
//   busy              high whenever the controller is not idle
// ---------------------------------------------------------------------------
module mult_8x8_quad_seq #(
   parameter int unsigned MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] R,
   output logic [3:0]  q_a,
   output logic [3:0]  q_b,
   output logic [1:0]  q_sel,
   output logic        q_valid,
   input  logic [7:0]  q_p,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_Q0   = 3'd1,
      S_Q1   = 3'd2,
      S_Q2   = 3'd3,
      S_Q3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Slot cycle counter value at which the multiplier output is sampled.
   localparam logic [1:0] LAST_CNT = 2'(MUL_LAT);

   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic        mode_q;
   logic [15:0] acc_q;
   logic [15:0] acc_d;
   logic [15:0] term_s;
   logic [15:0] r_q;
   logic        out_valid_q;
   logic        q_valid_q;
   logic [3:0]  q_a_q;
   logic [3:0]  q_b_q;
   logic [1:0]  q_sel_q;
   logic        busy_q;
   logic [1:0]  k_next_s;

   // Quadrant k uses A high nibble when k[1] is set, B high nibble when k[0] is set.
   function automatic logic [3:0] nib_a(input logic [1:0] k, input logic [7:0] a);
      return k[1] ? a[7:4] : a[3:0];
   endfunction

   function automatic logic [3:0] nib_b(input logic [1:0] k, input logic [7:0] b);
      return k[0] ? b[7:4] : b[3:0];
   endfunction

   // Place a partial product at its quadrant weight: shift 0, 4, 4, 8.
   function automatic logic [15:0] place(input logic [1:0] k, input logic [7:0] p);
      logic [15:0] res;
      case (k)
         2'd0:       res = {8'd0, p};
         2'd1, 2'd2: res = {4'd0, p, 4'd0};
         2'd3:       res = {p, 8'd0};
         default:    res = 16'd0;
      endcase
      return res;
   endfunction

   assign k_next_s = q_sel_q + 2'd1;

   // Accumulator next value from the returned partial product of the current quadrant.
   always_comb begin
      term_s = place(q_sel_q, q_p);
      if (mode_q) begin
         acc_d = acc_q | term_s;
      end else begin
         acc_d = acc_q + term_s;
      end
   end

   // Controller FSM with registered handshake and multiplier-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         mode_q      <= 1'b0;
         acc_q       <= 16'd0;
         r_q         <= 16'd0;
         out_valid_q <= 1'b0;
         q_valid_q   <= 1'b0;
         q_a_q       <= 4'd0;
         q_b_q       <= 4'd0;
         q_sel_q     <= 2'd0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // in_ready is always high here once rst is low.
               if (in_valid) begin
                  a_q       <= A;
                  b_q       <= B;
                  mode_q    <= mode;
                  acc_q     <= 16'd0;
                  cnt_q     <= 2'd0;
                  q_valid_q <= 1'b1;
                  q_sel_q   <= 2'd0;
                  q_a_q     <= A[3:0];
                  q_b_q     <= B[3:0];
                  busy_q    <= 1'b1;
                  state_q   <= S_Q0;
               end
            end
            S_Q0, S_Q1, S_Q2, S_Q3: begin
               if (cnt_q == LAST_CNT) begin
                  acc_q <= acc_d;
                  cnt_q <= 2'd0;
                  if (state_q == S_Q3) begin
                     q_valid_q   <= 1'b0;
                     q_a_q       <= 4'd0;
                     q_b_q       <= 4'd0;
                     r_q         <= acc_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     // Issue the next quadrant right away so slots are back to back.
                     q_valid_q <= 1'b1;
                     q_sel_q   <= k_next_s;
                     q_a_q     <= nib_a(k_next_s, a_q);
                     q_b_q     <= nib_b(k_next_s, b_q);
                     state_q   <= state_t'(state_q + 3'd1);
                  end
               end else begin
                  // Waiting on the multiplier pipeline; q_sel keeps the quadrant.
                  cnt_q     <= cnt_q + 2'd1;
                  q_valid_q <= 1'b0;
                  q_a_q     <= 4'd0;
                  q_b_q     <= 4'd0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               q_valid_q   <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   // in_ready must drop while rst is asserted and rise in the first cycle after it.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign R         = r_q;
   assign q_a       = q_a_q;
   assign q_b       = q_b_q;
   assign q_sel     = q_sel_q;
   assign q_valid   = q_valid_q;
   assign busy      = busy_q;

endmodule
